// File: rtl/axi_pkg.sv
// Shared AXI4 constants and helpers for the DMA engines.
// The read-engine FSM state type lives here so that the write engine can reuse it.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int         AXI_4KB         = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } rd_state_e;

  // log2 of the bytes per beat, i.e. the AxSIZE encoding
  function automatic int axi_size(input int data_width);
    int s;
    int bytes;
    s = 0;
    bytes = data_width / 8;
    while (bytes > 1) begin
      bytes = bytes >> 1;
      s++;
    end
    return s;
  endfunction

  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_burst_splitter.sv
// Picks the next INCR burst length: limited by remaining beats, MAX_BURST,
// and the beats left before the next 4KB page boundary.
module axi_burst_splitter
  import axi_pkg::*;
#(
  parameter int XFER_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_BURST  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic [11:0]           page_offset,
  input  logic [XFER_WIDTH-1:0] rem,
  output logic [LEN_WIDTH:0]    len
);

  localparam int SIZE = axi_size(DATA_WIDTH);
  localparam int CW   = (XFER_WIDTH > 13) ? XFER_WIDTH : 13;
  localparam int LW   = LEN_WIDTH + 1;

  logic [12:0]   page_bytes;
  logic [CW-1:0] page_beats;

  assign page_bytes = 13'(AXI_4KB) - {1'b0, page_offset};
  assign page_beats = CW'(page_bytes >> SIZE);

  always_comb begin
    len = LW'(MAX_BURST);
    if (CW'(rem) < CW'(len)) len = LW'(rem);
    if (page_beats < CW'(len)) len = LW'(page_beats);
  end

endmodule

// File: rtl/axi_master_read_engine.sv
// Multi-burst AXI4 read master: splits one DMA request into 4KB-safe INCR
// bursts, keeps several ARs in flight and streams R beats into the FIFO.
module axi_master_read_engine
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int XFER_WIDTH      = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] xfer_addr,
  input  logic [XFER_WIDTH-1:0] xfer_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  done_ack,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [LEN_WIDTH-1:0]  ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic                  fifo_wpush,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull
);

  localparam int SIZE = axi_size(DATA_WIDTH);
  localparam int LW   = LEN_WIDTH + 1;
  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);

  rd_state_e             state;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [XFER_WIDTH-1:0] ar_rem;
  logic [OW-1:0]         outstanding;
  logic [LW-1:0]         split_len;
  logic [LW-1:0]         cur_len;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  last_hs;
  logic                  bad_beat;
  logic                  ar_load;

  axi_burst_splitter #(
    .XFER_WIDTH (XFER_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_splitter (
    .page_offset (ar_addr[11:0]),
    .rem         (ar_rem),
    .len         (split_len)
  );

  assign ARSIZE     = 3'(SIZE);
  assign ARBURST    = AXI_BURST_INCR;
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign RREADY     = busy & ~fifo_wfull;
  assign r_hs       = RVALID & RREADY;
  assign fifo_wpush = r_hs;
  assign fifo_wdata = RDATA;
  assign ar_hs      = ARVALID & ARREADY;
  assign last_hs    = r_hs & RLAST;
  assign bad_beat   = r_hs & axi_resp_is_err(RRESP);

  // A bad beat accepted this cycle already blocks the next AR, so nothing new
  // is requested once an error has been seen.
  assign ar_load = busy && !ARVALID && (ar_rem != '0) &&
                   (outstanding < OW'(MAX_OUTSTANDING)) && !err && !bad_beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ar_addr     <= '0;
      ar_rem      <= '0;
      outstanding <= '0;
      cur_len     <= '0;
      ARVALID     <= 1'b0;
      ARADDR      <= '0;
      ARLEN       <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (xfer_beats != '0) begin
              ar_addr <= xfer_addr;
              ar_rem  <= xfer_beats;
              state   <= ST_RUN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          // cur_len remembers the loaded burst so the address/remainder
          // update on handshake matches what ARLEN advertised.
          if (ar_load) begin
            ARVALID <= 1'b1;
            ARADDR  <= ar_addr;
            ARLEN   <= LEN_WIDTH'(split_len - LW'(1));
            cur_len <= split_len;
          end else if (ar_hs) begin
            ARVALID <= 1'b0;
            ar_addr <= ar_addr + (ADDR_WIDTH'(cur_len) << SIZE);
            ar_rem  <= ar_rem - XFER_WIDTH'(cur_len);
          end
          if (ar_hs && !last_hs) begin
            outstanding <= outstanding + OW'(1);
          end else if (!ar_hs && last_hs) begin
            outstanding <= outstanding - OW'(1);
          end
          if (bad_beat) err <= 1'b1;
          if (((ar_rem == '0) || err) && (outstanding == '0) && !ARVALID) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
